// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and display configuration type for the 7-segment scanner
package seg_pkg;
  localparam int NUM_DIGITS_DEF = 4;
  localparam logic [NUM_DIGITS_DEF-1:0] AN_OFF = '1;
  localparam logic DP_OFF = 1'b1;
  typedef struct packed {
    logic [4*NUM_DIGITS_DEF-1:0] value;
    logic [NUM_DIGITS_DEF-1:0]   dp_mask;
    logic                        blank_lz;
  } disp_cfg_t;
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: load-side inputs and scanned display outputs of seg_scan
interface seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic [3:0]              digit_nib;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame;
  modport master(output load, value, dp_mask, blank_lz, input digit_nib, dp_n, an, frame);
  modport slave(input load, value, dp_mask, blank_lz, output digit_nib, dp_n, an, frame);
endinterface

// File: rtl/seg_scan_tick.sv
// scan_tick: free-running divider pulsing tick_o once every CLK_DIV cycles
module scan_tick #(parameter int CLK_DIV = 100000) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(CLK_DIV - 1);
  assign cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 7-segment scanner with frame-boundary commit and leading-zero blanking
module seg_scan import seg_pkg::*; #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
  } cfg_t;
  logic                  tick, wrap, wrap_q, lz, blank;
  logic [IW-1:0]         idx_q, idx_d;
  cfg_t                  in_cfg, shown_q, shown_d, pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_q, dp_d, frame_q;
  scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick_o(tick));
  // A load on the wrap tick goes straight to shown so it is never held back a frame
  always_comb begin
    in_cfg   = '{value: bus.value, dp_mask: bus.dp_mask, blank_lz: bus.blank_lz};
    wrap     = tick && idx_q == IW'(NUM_DIGITS - 1);
    idx_d    = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    shown_d  = wrap ? (bus.load ? in_cfg : (pend_v_q ? pend_q : shown_q)) : shown_q;
    pend_d   = bus.load && !wrap ? in_cfg : pend_q;
    pend_v_d = wrap ? 1'b0 : pend_v_q | bus.load;
    lz = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      lz = lz & (j < int'(idx_q) || shown_q.value[4*j +: 4] == 4'd0);
    blank = shown_q.blank_lz && idx_q != '0 && lz;
    an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    nib_d = blank ? 4'd0 : shown_q.value[4*idx_q +: 4];
    dp_d  = blank ? DP_OFF : ~shown_q.dp_mask[idx_q];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx_q    <= '0;
      shown_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      wrap_q   <= 1'b0;
      an_q     <= '1;
      nib_q    <= 4'd0;
      dp_q     <= DP_OFF;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shown_q  <= shown_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      wrap_q   <= wrap;
      an_q     <= an_d;
      nib_q    <= nib_d;
      dp_q     <= dp_d;
      frame_q  <= wrap_q;
    end
  assign bus.an        = an_q;
  assign bus.digit_nib = nib_q;
  assign bus.dp_n      = dp_q;
  assign bus.frame     = frame_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan with CLK_DIV=4, NUM_DIGITS=4
module tb_seg_scan;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] an_c[16], nib_c[16];
  logic       dpn_c[16], frm_c[16];
  seg_scan_if #(.NUM_DIGITS(4)) bus();
  seg_scan #(.CLK_DIV(4), .NUM_DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic blz);
    bus.load = ld; bus.value = v; bus.dp_mask = dp; bus.blank_lz = blz;
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    drive(1'b1, v, dp, blz);
    step();
    bus.load = 1'b0;
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin step(); n++; end while (bus.frame !== 1'b1 && n < 40);
    n_cmp++;
    if (bus.frame !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_frame: frame=%b, required 1 within 40 cycles", bus.frame);
    end
  endtask
  task automatic capture();
    for (int i = 0; i < 16; i++) begin
      an_c[i] = bus.an; nib_c[i] = bus.digit_nib; dpn_c[i] = bus.dp_n; frm_c[i] = bus.frame;
      step();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    step(); step();
    n_cmp++;
    if ({bus.an, bus.digit_nib, bus.dp_n, bus.frame} !== 10'b1111_0000_1_0) begin
      n_bad++;
      $display("FAIL reset_out: got %b expected 1111000010", {bus.an, bus.digit_nib, bus.dp_n, bus.frame});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      logic [9:0] got, exp;
      step();
      got = {bus.an, bus.digit_nib, bus.dp_n, bus.frame};
      exp = {4'hF ^ (4'h1 << (((k - 1) / 4) % 4)), 4'h0, 1'b1, k == 17 || k == 33};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL scan_order[%0d]: got %b expected %b", k, got, exp);
      end
    end
  endtask
  task automatic test_nibble_dp();
    logic [3:0] en[4] = '{4'hF, 4'hA, 4'h2, 4'h1};
    do_load(16'h12AF, 4'b0100, 1'b0);
    wait_frame();
    capture();
    for (int i = 0; i < 16; i++) begin
      int d = i / 4;
      logic [9:0] got, exp;
      got = {an_c[i], nib_c[i], dpn_c[i], frm_c[i]};
      exp = {4'hF ^ (4'h1 << d), en[d], d != 2, i == 0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL nibble_dp[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask
  task automatic test_no_tearing();
    for (int i = 0; i < 4; i++) step();
    do_load(16'h1234, 4'b0000, 1'b0);
    for (int i = 6; i <= 16; i++) begin
      logic [8:0] got, exp;
      step();
      got = {bus.an, bus.digit_nib, bus.frame};
      exp = i == 16 ? {4'b1110, 4'h4, 1'b1} : {4'hF ^ (4'h1 << (i / 4)), i < 12 ? 4'h2 : 4'h1, 1'b0};
      if (i >= 8) begin
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL no_tearing[%0d]: got %b expected %b", i, got, exp);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [8:0] got;
    do_load(16'h1111, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step();
    do_load(16'h2222, 4'b0000, 1'b0);
    wait_frame();
    capture();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({an_c[i], nib_c[i]} !== {4'hF ^ (4'h1 << (i / 4)), 4'h2}) begin
        n_bad++;
        $display("FAIL newest_wins[%0d]: got an=%b nib=%h expected nib=2", i, an_c[i], nib_c[i]);
      end
    end
    for (int i = 0; i < 14; i++) step();
    drive(1'b1, 16'h3333, 4'b0000, 1'b0);
    step();
    bus.load = 1'b0;
    step();
    got = {bus.an, bus.digit_nib, bus.frame};
    n_cmp++;
    if (got !== 9'b1110_0011_1) begin
      n_bad++;
      $display("FAIL bypass: got %b expected 111000111", got);
    end
    capture();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (nib_c[i] !== 4'h3) begin
        n_bad++;
        $display("FAIL bypass_frame[%0d]: got nib=%h expected 3", i, nib_c[i]);
      end
    end
  endtask
  task automatic test_blanking();
    logic [3:0] en[4] = '{4'h0, 4'h5, 4'h0, 4'h0};
    do_load(16'h0050, 4'b0000, 1'b1);
    wait_frame();
    capture();
    for (int i = 0; i < 16; i++) begin
      int d = i / 4;
      logic [8:0] got, exp;
      got = {an_c[i], nib_c[i], dpn_c[i]};
      exp = d < 2 ? {4'hF ^ (4'h1 << d), en[d], 1'b1} : 9'b1111_0000_1;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL blank_0050[%0d]: got %b expected %b", i, got, exp);
      end
    end
    do_load(16'h0000, 4'b1111, 1'b1);
    wait_frame();
    capture();
    for (int i = 0; i < 16; i++) begin
      logic [8:0] got, exp;
      got = {an_c[i], nib_c[i], dpn_c[i]};
      exp = i < 4 ? 9'b1110_0000_0 : 9'b1111_0000_1;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL blank_0000[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask
  task automatic test_mid_reset();
    do_load(16'hBEEF, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    drive(1'b1, 16'h5555, 4'hF, 1'b0);
    step();
    n_cmp++;
    if ({bus.an, bus.digit_nib, bus.dp_n, bus.frame} !== 10'b1111_0000_1_0) begin
      n_bad++;
      $display("FAIL mid_reset_out: got %b expected 1111000010", {bus.an, bus.digit_nib, bus.dp_n, bus.frame});
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      logic [8:0] got, exp;
      step();
      got = {bus.an, bus.digit_nib, bus.frame};
      exp = {4'hF ^ (4'h1 << (((k - 1) / 4) % 4)), 4'h0, k == 17};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL after_reset[%0d]: got %b expected %b", k, got, exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_nibble_dp();
    test_no_tearing();
    test_back_to_back();
    test_blanking();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexing scanner for the board's 4-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder. It latches a 16-bit display value from the CPU peripheral bus and steps through the digits at a fixed refresh rate. For each digit it presents one 4-bit nibble to the decoder, plus an active-low anode select and a decimal-point bit. New values are committed only at frame boundaries, so the display never shows a torn mix of old and new digits.

## Interface
- `CLK_DIV`, 100000: clock cycles each digit stays lit; legal range ≥ 2.
- `NUM_DIGITS`, 4: number of digits scanned; digit 0 is the rightmost digit.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `load`  in  1  single-cycle strobe; captures `value`, `dp_mask` and `blank_lz`.
- `value`  in  4*NUM_DIGITS  display value; nibble i belongs to digit i.
- `dp_mask`  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
- `blank_lz`  in  1  1 = suppress leading zeros.
- `digit_nib`  out  4  nibble sent to the segment decoder.
- `dp_n`  out  1  decimal point, active-low.
- `an`  out  NUM_DIGITS  anode enables, active-low, at most one bit low.
- `frame`  out  1  one-cycle pulse on the clock in which the scan wraps to digit 0.

## Operation
- State:
  - `div_cnt` (0..CLK_DIV-1)
  - `idx` (0..NUM_DIGITS-1)
  - `shown` register (value, dp_mask, blank_lz)
  - `pending` register (same fields)
  - `pend_v` flag
- `tick` is asserted when `div_cnt == CLK_DIV-1`.
  - On tick: `div_cnt` returns to 0 and `idx` advances; it wraps from NUM_DIGITS-1 to 0.
  - Otherwise `div_cnt` increments.
- `load` writes `pending` and sets `pend_v`. A second `load` before commit overwrites `pending`; the newest value wins and no error is raised.
- Commit happens on a tick where `idx == NUM_DIGITS-1` (the wrap):
  - If `pend_v` is set, `shown` ← `pending` and `pend_v` is cleared.
  - If `load` is asserted in that same cycle, the incoming `load` data bypasses `pending`, is committed directly into `shown`, and `pend_v` ends cleared.
- Leading-zero blanking: digit i (i > 0) is blank when `shown.blank_lz` is set and nibbles i..NUM_DIGITS-1 of `shown.value` are all zero. Digit 0 is never blanked.
- A blanked digit drives `an` all ones, `dp_n` = 1 and `digit_nib` = 0.
- Unblanked digit: `an` has bit `idx` = 0 and all other bits 1; `digit_nib` = nibble `idx`; `dp_n` = ~`dp_mask[idx]`.

## Timing
- All outputs are registered and reflect `idx` and `shown` as of the previous clock edge.
- Reset values: `div_cnt` = 0, `idx` = 0, `shown` = 0, `pending` = 0, `pend_v` = 0.
- Output reset values: `an` = all ones, `digit_nib` = 0, `dp_n` = 1, `frame` = 0.
- On the first clock after `rst_n` rises, `an` = ...1110 and `digit_nib` = 0.
- Each digit is lit for exactly CLK_DIV cycles; a full frame is NUM_DIGITS*CLK_DIV cycles.
- `frame` pulses in the output cycle where digit 0 first appears after a wrap. It does not pulse after reset.
- Commit-to-display latency: the new `shown` is visible on the outputs one clock after the wrap tick.
- Load-to-display latency: worst case one full frame plus 1 cycle.
- `rst_n` low mid-frame: all state returns to reset values on the next edge and any pending load is discarded.
- `load` asserted while `rst_n` is low is ignored.

## Structure
- Shared package `seg_pkg`:
  - `NUM_DIGITS_DEF` = 4
  - `AN_OFF` (all ones)
  - `DP_OFF` = 1
  - typedef `disp_cfg_t` {value, dp_mask, blank_lz}
- `div_cnt` width is `$clog2(CLK_DIV)`; `idx` width is `$clog2(NUM_DIGITS)`, minimum 1.
- One sub-module, `scan_tick`: a parameterised divider producing `tick`, with the same reset semantics.
- The top level holds `idx`, the commit logic, blanking and the output registers.
- The segment decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios run with CLK_DIV = 4 and NUM_DIGITS = 4.
- **Reset and scan order.** Release reset with no load. `an` cycles 1110, 1101, 1011, 0111, 4 cycles each; `digit_nib` = 0 throughout; `frame` pulses every 16 cycles, starting after the first wrap.
- **Nibble mapping and DP.** Load `value` = 16'h12AF, `dp_mask` = 4'b0100. After the next wrap, `digit_nib` shows F, A, 2, 1 for `idx` 0..3, and `dp_n` = 0 only while `an` = 1011.
- **No tearing.** Load 16'h1234 mid-frame while `idx` = 1. `idx` 2 and 3 still show the old nibbles; 4 is shown at the next `frame` cycle.
- **Back-to-back loads and bypass.** Load 16'h1111 and then 16'h2222 within one frame; only 2222 is ever displayed. Separately, load 16'h3333 on the wrap tick; it is displayed on the immediately following digit-0 cycle.
- **Leading-zero blanking.** Load 16'h0050 with `blank_lz` = 1. `an` stays 1111 during `idx` 2 and 3, digits 0 and 1 show 0 and 5. Load 16'h0000: only digit 0 lights.
- **Mid-frame reset.** Load 16'hBEEF, then pull `rst_n` low during `idx` 2 before the wrap. Outputs return to reset values the next cycle, and after release `digit_nib` shows 0, not F.
